hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writes. It produces a load-use stall
// and registered EX-stage forwarding selects. Optional counters are enabled with HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter  int REG_ADDR_W = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_LAT   = 1,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_regwrite,
  input  logic                  issue_is_load,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic                  src_a_used,
  input  logic                  src_b_used,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_a,
  output logic [SEL_W-1:0]      fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           fwd_cnt
`endif
);

  localparam logic [SEL_W-1:0] LOAD_LAT_SEL = SEL_W'(LOAD_LAT);
  localparam logic [SEL_W-1:0] DEPTH_SEL    = SEL_W'(DEPTH);

  // Stage k holds the tag of the instruction k stages past ID.
  logic                  r_valid [1:DEPTH];
  logic [REG_ADDR_W-1:0] r_rd    [1:DEPTH];
  logic                  r_load  [1:DEPTH];
  logic [SEL_W-1:0]      r_fwd   [2];

  logic [REG_ADDR_W-1:0] w_src      [2];
  logic                  w_used     [2];
  logic                  w_hit      [2];
  logic [SEL_W-1:0]      w_k        [2];
  logic                  w_ld       [2];
  logic [SEL_W-1:0]      w_fwd_nxt  [2];
  logic                  w_stall_raw;
  logic                  w_stall;
  logic                  w_issue;

  assign w_src[0]  = src_a;
  assign w_src[1]  = src_b;
  assign w_used[0] = src_a_used;
  assign w_used[1] = src_b_used;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    w_stall_raw = 1'b0;
    for (int op = 0; op < 2; op++) begin
      w_hit[op]     = 1'b0;
      w_k[op]       = '0;
      w_ld[op]      = 1'b0;
      w_fwd_nxt[op] = '0;
    end
    // NOTE: blocking assignments here, so the later statements see the values just computed.
    // The scan runs oldest to youngest, so the smallest matching stage is the one kept.
    for (int op = 0; op < 2; op++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (w_used[op] && r_valid[k] && (r_rd[k] == w_src[op]) && (w_src[op] != '0)) begin
          w_hit[op] = 1'b1;
          w_k[op]   = SEL_W'(k);
          w_ld[op]  = r_load[k];
        end
      end
      if (w_hit[op] && w_ld[op] && (w_k[op] <= LOAD_LAT_SEL))
        w_stall_raw = 1'b1;
    end
    w_stall = ~flush & w_stall_raw;
    w_issue = issue_valid & ~w_stall & ~flush;
    // A producer in the last stage has already written the regfile, which the consumer reads directly.
    for (int op = 0; op < 2; op++) begin
      if (w_issue && w_hit[op] && (w_k[op] != DEPTH_SEL))
        w_fwd_nxt[op] = SEL_W'(w_k[op] + 1'b1);
    end
  end

  assign stall = w_stall;
  assign fwd_a = r_fwd[0];
  assign fwd_b = r_fwd[1];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the tag array is a handful of flops rather than a RAM, so it is cleared on reset.
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_rd[k]    <= '0;
        r_load[k]  <= 1'b0;
      end
      r_fwd[0] <= '0;
      r_fwd[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every stage shifts using its pre-edge neighbour.
      for (int k = DEPTH; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_rd[k]    <= r_rd[k-1];
        r_load[k]  <= r_load[k-1];
      end
      r_valid[1] <= w_issue & issue_regwrite & (issue_rd != '0);
      r_rd[1]    <= issue_rd;
      r_load[1]  <= issue_is_load;
      r_fwd[0]   <= w_fwd_nxt[0];
      r_fwd[1]   <= w_fwd_nxt[1];
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;
  logic [1:0]  w_fwd_inc;
  logic [16:0] w_fwd_sum;

  assign w_fwd_inc = {1'b0, (w_fwd_nxt[0] != '0)} + {1'b0, (w_fwd_nxt[1] != '0)};
  assign w_fwd_sum = {1'b0, r_fwd_cnt} + {15'd0, w_fwd_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      r_fwd_cnt <= w_fwd_sum[16] ? 16'hFFFF : w_fwd_sum[15:0];
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule
